// File: rtl/pcileech_eth_pkg.sv
// Shared definitions for the RMII receive path.
//   - rx_state_t   : receiver state machine encoding
//   - DIBIT_*      : preamble and SFD-tail dibit values as seen on RXD[1:0]
//   - CRC_*        : Ethernet CRC-32 polynomial (reflected), seed and good-frame residue
//   - crc32_byte() : one byte of LSB-first CRC-32 update, no final inversion
package pcileech_eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_t;

  // 0x55 sent LSB-first is dibit 01 repeated; 0xD5 ends with dibit 11.
  localparam logic [1:0]  DIBIT_PREAMBLE = 2'b01;
  localparam logic [1:0]  DIBIT_SFD_TAIL = 2'b11;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Register value after running a frame plus its own FCS through the CRC.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam int unsigned LEN_W = 11;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/pcileech_eth_crc32.sv
// Byte-wide Ethernet CRC-32 accumulator.
//   clk  : clock
//   rst  : synchronous active-high reset, loads CRC_INIT
//   init : synchronous reload with CRC_INIT (start of frame)
//   en   : fold data into the running CRC this cycle
//   data : byte to accumulate
//   crc  : running CRC register (not inverted)
module pcileech_eth_crc32
  import pcileech_eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/pcileech_rmii_rx.sv
// RMII receive deframer: preamble/SFD detection, dibit-to-byte assembly,
// CRC-32 and length qualification, and good/bad frame counters.
//   clk          : 50 MHz RMII reference clock
//   rst          : synchronous active-high reset
//   eth_crs_dv   : RMII CRS_DV
//   eth_rx_data  : RMII RXD[1:0], LSB-first dibits
//   eth_rx_err   : PHY receive error
//   rx_data      : received byte (FCS included)
//   rx_valid     : one-cycle strobe per byte, no backpressure
//   rx_sof       : with rx_valid on the first byte after the SFD
//   rx_eof       : one-cycle end-of-frame status pulse
//   rx_good      : valid with rx_eof; CRC, length and error checks all passed
//   cnt_ok       : saturating count of good frames
//   cnt_bad      : saturating count of bad frames
module pcileech_rmii_rx
  import pcileech_eth_pkg::*;
#(
  parameter int unsigned PARAM_MAX_LEN = 1522,
  parameter int unsigned PARAM_MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eth_crs_dv,
  input  logic [1:0]  eth_rx_data,
  input  logic        eth_rx_err,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_good,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_bad
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PARAM_MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(PARAM_MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  rx_state_t        state;

  // One-sample delay of the RMII pins.
  logic             d1_crs;
  logic [1:0]       d1_data;
  logic             d1_err;

  // Set once the line has been seen quiet; keeps the tail of a frame that was
  // in flight during reset from being mistaken for a new preamble.
  logic             line_quiet_seen;

  logic [1:0]       phase;
  logic [5:0]       part;
  logic [LEN_W-1:0] len;
  logic             err_seen;
  logic [31:0]      crc;

  logic             end_cond;
  logic             byte_done;
  logic             byte_emit;
  logic             crc_init;
  logic             frame_good;
  logic [7:0]       byte_next;

  // Carrier must be low for two consecutive samples to end a frame; a
  // single low sample is a false-carrier toggle and still carries data.
  always_comb begin
    end_cond   = !d1_crs && !eth_crs_dv;
    byte_next  = {d1_data, part};
    byte_done  = (state == ST_DATA) && !end_cond && (phase == 2'd3);
    byte_emit  = byte_done && (len < MAX_LEN);
    crc_init   = (state == ST_PREAMBLE) && !end_cond && (d1_data == DIBIT_SFD_TAIL);
    frame_good = (crc == CRC_RESIDUE) &&
                 (len >= MIN_LEN) && (len <= MAX_LEN) &&
                 (phase == 2'd0) && !err_seen;
  end

  pcileech_eth_crc32 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (byte_emit),
    .data (byte_next),
    .crc  (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      d1_crs          <= 1'b0;
      d1_data         <= '0;
      d1_err          <= 1'b0;
      line_quiet_seen <= 1'b0;
      phase           <= '0;
      part            <= '0;
      len             <= '0;
      err_seen        <= 1'b0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      rx_sof          <= 1'b0;
      rx_eof          <= 1'b0;
      rx_good         <= 1'b0;
      cnt_ok          <= '0;
      cnt_bad         <= '0;
    end else begin
      d1_crs  <= eth_crs_dv;
      d1_data <= eth_rx_data;
      d1_err  <= eth_rx_err;

      if (end_cond) begin
        line_quiet_seen <= 1'b1;
      end

      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_good  <= 1'b0;

      if (rx_eof) begin
        if (rx_good) begin
          if (cnt_ok != '1) begin
            cnt_ok <= cnt_ok + 16'd1;
          end
        end else begin
          if (cnt_bad != '1) begin
            cnt_bad <= cnt_bad + 16'd1;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (line_quiet_seen && d1_crs && (d1_data == DIBIT_PREAMBLE)) begin
            state <= ST_PREAMBLE;
          end
        end

        ST_PREAMBLE: begin
          if (end_cond) begin
            state <= ST_IDLE;
          end else if (d1_data == DIBIT_PREAMBLE) begin
            state <= ST_PREAMBLE;
          end else if (d1_data == DIBIT_SFD_TAIL) begin
            state    <= ST_DATA;
            phase    <= '0;
            part     <= '0;
            len      <= '0;
            err_seen <= 1'b0;
          end else begin
            state <= ST_DROP;
          end
        end

        ST_DATA: begin
          if (end_cond) begin
            state   <= ST_IDLE;
            rx_eof  <= 1'b1;
            rx_good <= frame_good;
          end else begin
            if (d1_err) begin
              err_seen <= 1'b1;
            end
            phase <= phase + 2'd1;
            case (phase)
              2'd0:    part[1:0] <= d1_data;
              2'd1:    part[3:2] <= d1_data;
              2'd2:    part[5:4] <= d1_data;
              default: part      <= part;
            endcase
            if (byte_done) begin
              if (len != LEN_SAT) begin
                len <= len + LEN_W'(1);
              end
              // Bytes past the length limit still count toward len but are
              // not presented, so the frame is flagged bad at its end.
              if (byte_emit) begin
                rx_data  <= byte_next;
                rx_valid <= 1'b1;
                rx_sof   <= (len == '0);
              end
            end
          end
        end

        ST_DROP: begin
          if (end_cond) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
